rr_arb8: RTL and testbench
==========================

Name: rr_arb8

Overview:
- 8-requester round-robin arbiter for one shared resource.
- The grant index is 3 bits wide. It drives a 3-to-8 one-hot decode that produces the per-requester grant lines.
- Sits between eight client blocks and the shared resource. Selects exactly one owner at a time, holds the grant until that owner releases, and rotates fairly.

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles per owner while other requests are pending. Only used when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  level request, bit i = requester i. A requester holds its bit high for as long as it needs the resource.
- gnt  output  8  one-hot grant, all zero when no owner.
- gnt_idx  output  3  index of current or last owner.
- gnt_valid  output  1  high while an owner holds the grant.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, gnt_valid=0, gnt=8'h00.
  - gnt_idx=3'd7, so requester 0 has highest priority on the first arbitration.
  - hold_cnt=0.
- All state is registered. gnt is the decoded gnt_idx gated by gnt_valid. gnt_idx and gnt_valid come straight from flops. Outputs are never a combinational function of req.
- Priority order: scan from (gnt_idx+1) mod 8 upward with wrap-around (7 -> 0). The first set bit wins.
- IDLE:
  - If req != 0 at edge N, then after edge N: state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0. Latency is 1 cycle from request to grant.
  - If req == 0, stay in IDLE. gnt_idx keeps its last value.
- GRANT, owner still requesting (req[gnt_idx]=1):
  - Hold the grant.
  - Increment hold_cnt, saturating.
- GRANT, owner releases (req[gnt_idx]=0 at edge N):
  - Re-arbitrate among the other bits in the same edge, priority from gnt_idx+1.
  - If any other request is set, the new owner is granted after edge N. Back-to-back hand-over, no idle cycle, hold_cnt=0.
  - If no other request is set: state=IDLE, gnt_valid=0 after edge N.
- The owner cannot be re-granted in the same edge it releases. It is scanned last in the next arbitration.
- Exactly one gnt bit is high in GRANT; all bits are zero in IDLE. Assertion: gnt is one-hot or zero.
- Simultaneous requests: resolved purely by rotating priority. No starvation; each requester waits at most 7 grants.
- Reset mid-grant: gnt drops immediately (asynchronously). After reset release, arbitration restarts from index 0.
- req changes on bits other than the owner's during GRANT do not affect the grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt reaches HOLD_MAX-1 and any other req bit is set, the grant is forcibly rotated at the next edge to the next requester in priority order, and hold_cnt is cleared.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates at HOLD_MAX-1.
  - The pre-empted requester may re-request and waits its turn.
- Not defined:
  - Grant is held indefinitely until the owner releases.
  - hold_cnt logic is absent.

Decomposition:
- Shared package rr_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - N_REQ=8, IDX_W=3.
  - Function next_winner(req, last_idx), returning the index and a found flag.
- One sub-module: dec3to8, a combinational 3-to-8 one-hot decoder with enable (gnt_valid). Instantiated once for gnt.

Test Plan:
- Reset, then req=8'h01 -> gnt=8'h01, gnt_idx=0, gnt_valid=1 one cycle later. Drop req -> gnt=0, gnt_valid=0 next cycle.
- req=8'hFF held, each owner drops its bit for 1 cycle after 2 cycles of ownership, then re-raises it -> grant order 0,1,2,...,7,0 with no idle cycle between owners.
- Owner 3 holds, req=8'h88 -> owner 3 releases -> gnt=8'h80 next edge. Release 7 with req=8'h08 -> gnt wraps to 8'h08.
- Assert rst_n=0 mid-grant (gnt=8'h20) -> gnt=0 immediately. Release with req=8'h24 -> gnt=8'h04 (priority restarts at 0).
- ARB_TIMEOUT_EN defined, HOLD_MAX=4, req=8'h03 held constant -> gnt alternates 8'h01/8'h02 every 4 cycles. With req=8'h01 only -> gnt=8'h01 held indefinitely.
- ARB_TIMEOUT_EN undefined, req=8'h03 held 100 cycles -> gnt stays 8'h01 throughout.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// The scan function returns the first set request after last_idx, wrapping, with last_idx itself checked last.
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

  function automatic win_t next_winner(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] last_idx);
    win_t             w;
    logic [IDX_W-1:0] cand;
    w.found = 1'b0;
    w.idx   = last_idx;
    // Walk from farthest to nearest so the nearest set bit is the last one written.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_idx + k[IDX_W-1:0];
      if (req[cand]) begin
        w.found = 1'b1;
        w.idx   = cand;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/rr_arb8_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] dec
);
  always_comb begin
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter; grant held until the owner releases.
// Optional macro ARB_TIMEOUT_EN enables forced rotation after HOLD_MAX cycles under contention.
//
// state    | meaning
// ST_IDLE  | no owner, gnt all zero, waiting for any request
// ST_GRANT | idx_q owns the resource until it drops its request
module rr_arb8
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] others;
  win_t win_all, win_oth;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
`endif

  assign others  = req & ~(N_REQ'(1) << idx_q);
  assign win_all = next_winner(req, idx_q);
  assign win_oth = next_winner(others, idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd7;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_all.found) begin
          state_d = ST_GRANT;
          idx_d   = win_all.idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          if (win_oth.found) begin
            idx_d = win_oth.idx;
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting: pre-empt only when someone else is waiting.
        else if (hold_q == HOLD_LAST) begin
          if (win_oth.found) begin
            idx_d  = win_oth.idx;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == ST_GRANT);
    gnt_idx   = idx_q;
  end

  dec3to8 u_dec (
    .idx (gnt_idx),
    .en  (gnt_valid),
    .dec (gnt)
  );

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_hold_range:  assert property (@(posedge clk) (HOLD_MAX >= 2 && HOLD_MAX <= 255));
endmodule

// File: tb/tb_rr_arb8.sv
// Randomized and directed bench for rr_arb8 against a queue-free index-level reference model.
module tb_rr_arb8;
  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  rr_arb8 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_idx;
  bit m_valid;
  int m_hold;
  int m_age;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int scan(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (last + k) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt();
    logic [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_idx = 7; m_valid = 0; m_hold = 0; m_age = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int prev, w;
    logic [7:0] oth;
    prev = m_valid ? m_idx : -1;
    if (!m_valid) begin
      w = scan(r, m_idx);
      if (w >= 0) begin m_idx = w; m_valid = 1; m_hold = 0; end
    end else begin
      oth = r;
      oth[m_idx] = 1'b0;
      w = scan(oth, m_idx);
      if (!r[m_idx]) begin
        if (w >= 0) begin m_idx = w; m_hold = 0; end
        else m_valid = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_hold == HM - 1) begin
          if (w >= 0) begin m_idx = w; m_hold = 0; end
        end else m_hold++;
`endif
      end
    end
    if (!m_valid) m_age = 0;
    else if (m_idx != prev) m_age = 1;
    else m_age++;
  endtask

  task automatic check_model(input string tag);
    check_val({tag, "_gnt"}, gnt, exp_gnt());
    check_val({tag, "_idx"}, {5'd0, gnt_idx}, 8'(m_idx));
    check_val({tag, "_vld"}, {7'd0, gnt_valid}, {7'd0, m_valid});
  endtask

  task automatic cycle(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    req = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ord[$];
    logic [7:0] r;
    int last_seen;

    model_reset();
    @(negedge clk);
    check_model("rst0");
    rst_n = 1'b1;

    // Single requester up and down
    cycle(8'h01, "single_up");
    check_val("single_gnt", gnt, 8'h01);
    cycle(8'h00, "single_dn");
    check_val("single_off", gnt, 8'h00);

    // All requesting, owners release after two cycles
    do_reset();
    last_seen = -1;
    for (int c = 0; c < 60 && ord.size() < 9; c++) begin
      r = 8'hFF;
      if (m_valid && m_age == 2) r[m_idx] = 1'b0;
      cycle(r, "rot");
      if (gnt_valid && int'(gnt_idx) != last_seen) begin
        ord.push_back(int'(gnt_idx));
        last_seen = int'(gnt_idx);
      end
    end
    check_val("rot_count", 8'(ord.size()), 8'd9);
    for (int i = 0; i < ord.size(); i++) check_val($sformatf("rot_order%0d", i), 8'(ord[i]), 8'(i % 8));

    // Hand-over 3 -> 7 -> wrap to 3
    do_reset();
    cycle(8'h08, "ho3");
    cycle(8'h88, "ho3_hold");
    check_val("ho3_gnt", gnt, 8'h08);
    cycle(8'h80, "ho7");
    check_val("ho7_gnt", gnt, 8'h80);
    cycle(8'h08, "howrap");
    check_val("howrap_gnt", gnt, 8'h08);

    // Reset in the middle of a grant
    do_reset();
    cycle(8'h20, "mid5");
    check_val("mid5_gnt", gnt, 8'h20);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_gnt", gnt, 8'h00);
    check_model("async");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h24, "restart");
    check_val("restart_gnt", gnt, 8'h04);

    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      cycle(8'h03, "to_alt");
      check_val($sformatf("to_alt%0d", k), gnt, (((k - 1) / HM) % 2 == 1) ? 8'h02 : 8'h01);
    end
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(8'h01, "to_solo");
      check_val("to_solo_gnt", gnt, 8'h01);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      cycle(8'h03, "hold");
      check_val("hold_gnt", gnt, 8'h01);
    end
`endif

    // Random traffic, owner tends to keep its request
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      else if (m_valid && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
      cycle(r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
